hazard_ctrl: RTL

Pipeline hazard and memory-wait controller for the 5-stage RISC-V datapath.
- Generates the datapath's StallF/StallD/FlushD/FlushE/ForwardAE/ForwardBE controls.
- Adds stage-E/M stall and W-bubble control for a multi-cycle data memory (req/ready handshake).
- Detects memory timeout and freezes the core with a sticky error.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_ctrl_sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / memory-wait controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // The M stage holds the younger result, so it wins over W.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       we_m,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    else                                             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: the default copy first keeps this block free of inferred latches.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + ONE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use and branch
// handling, plus stall/timeout control for a multi-cycle data memory.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_t      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic     lw_stall;
  logic     mem_stall;
  fwd_sel_t fwd_a, fwd_b;

  assign lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  // A request dropped mid-wait is treated exactly like a ready response.
  assign mem_stall = MemReqM && !MemReadyM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      WAIT: begin
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ERR: state_d = ERR;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    MemErr = 1'b0;
    fwd_a  = fwd_select(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    fwd_b  = fwd_select(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
    if (!reset) begin
      // Bubble every stage while reset is held so nothing stale retires.
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
      fwd_a  = FWD_RF;
      fwd_b  = FWD_RF;
    end else if ((state_q == ERR) || mem_stall) begin
      // Freeze F..M and bubble W; branch/load-use resolve after release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
      MemErr = (state_q == ERR);
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || lw_stall;
    end
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (StallF),
    .cnt_o (StallCycles)
  );

endmodule
